// File: rtl/debug_ctrl.sv
// debug_ctrl: UART-driven program loader, run/step control and PC/register/memory dump for the MIPS pipeline.
// Optional feature: define DEBUG_CYCLE_COUNT_EN to append a 32-bit run/step cycle count after the memory dump.
module debug_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int NUM_REGS   = 32,
    parameter int MEM_WORDS  = 32,
    parameter int MAX_INSTR  = 256
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_rx_valid,
    input  logic [BYTE_WIDTH-1:0]       i_rx_data,
    output logic                        o_tx_valid,
    output logic [BYTE_WIDTH-1:0]       o_tx_data,
    input  logic                        i_tx_ready,
    input  logic                        i_finish,
    input  logic [DATA_WIDTH-1:0]       i_pc,
    input  logic [DATA_WIDTH-1:0]       i_reg,
    input  logic [DATA_WIDTH-1:0]       i_mem,
    output logic [$clog2(NUM_REGS)-1:0] o_reg_addr,
    output logic [DATA_WIDTH-1:0]       o_mem_addr,
    output logic [DATA_WIDTH-1:0]       o_instruccion,
    output logic [DATA_WIDTH-1:0]       o_address,
    output logic                        o_loading,
    output logic                        o_start,
    output logic                        o_step,
    output logic                        o_busy
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int BPW = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [15:0] LIM_W = 16'(BPW - 1);
    localparam logic [BYTE_WIDTH-1:0] CMD_L = 'h4C;
    localparam logic [BYTE_WIDTH-1:0] CMD_R = 'h52;
    localparam logic [BYTE_WIDTH-1:0] CMD_S = 'h53;
`ifdef DEBUG_CYCLE_COUNT_EN
    localparam logic [15:0] LIM_C = 16'(32 / BYTE_WIDTH - 1);
`endif

    typedef enum logic [3:0] {
        IDLE, LOAD_LEN, LOAD_DATA, RUN, STEP, DUMP_PC, DUMP_REG, DUMP_MEM
`ifdef DEBUG_CYCLE_COUNT_EN
        , DUMP_CNT
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [2*BYTE_WIDTH-1:0] len_q, len_d, len_new;
    logic [31:0]             cnt_q, cnt_d;
    logic [15:0]             bcnt_q, bcnt_d, lim;
    logic [DATA_WIDTH-1:0]   sh_q, sh_d, rx_word, src;
    logic                    full_q, full_d;
    logic                    loading_q, loading_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d, addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [RW-1:0]           reg_addr_q, reg_addr_d;
    logic                    load_word, word_done, sect_done;
`ifdef DEBUG_CYCLE_COUNT_EN
    logic [31:0]             cyc_q, cyc_d;
`endif

    // Shared decode: byte assembly, word/section completion of the dump and the word capture source
    always_comb begin
        rx_word   = (sh_q >> BYTE_WIDTH) | (DATA_WIDTH'(i_rx_data) << (DATA_WIDTH - BYTE_WIDTH));
        len_new   = {i_rx_data, len_q[2*BYTE_WIDTH-1:BYTE_WIDTH]};
        load_word = state_q == LOAD_DATA && i_rx_valid && bcnt_q == LIM_W;
`ifdef DEBUG_CYCLE_COUNT_EN
        lim       = state_q == DUMP_CNT ? LIM_C : LIM_W;
        word_done = full_q && i_tx_ready && bcnt_q == lim;
        sect_done = word_done && (state_q == DUMP_PC || state_q == DUMP_CNT
                    || (state_q == DUMP_REG && cnt_q == 32'(NUM_REGS - 1))
                    || (state_q == DUMP_MEM && cnt_q == 32'(MEM_WORDS - 1)));
        src       = state_q == DUMP_PC ? i_pc : state_q == DUMP_REG ? i_reg
                    : state_q == DUMP_MEM ? i_mem : DATA_WIDTH'(cyc_q);
`else
        lim       = LIM_W;
        word_done = full_q && i_tx_ready && bcnt_q == lim;
        sect_done = word_done && (state_q == DUMP_PC
                    || (state_q == DUMP_REG && cnt_q == 32'(NUM_REGS - 1))
                    || (state_q == DUMP_MEM && cnt_q == 32'(MEM_WORDS - 1)));
        src       = state_q == DUMP_PC ? i_pc : state_q == DUMP_REG ? i_reg : i_mem;
`endif
    end

    // State register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic: commands in IDLE, framed load, run/step, then the dump sections in order
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (i_rx_valid) state_d = i_rx_data == CMD_L ? LOAD_LEN : i_rx_data == CMD_R ? RUN
                                                 : i_rx_data == CMD_S ? STEP : IDLE;
            LOAD_LEN:  if (i_rx_valid && bcnt_q == 16'd1) state_d = len_new == '0 ? IDLE : LOAD_DATA;
            LOAD_DATA: if (load_word && cnt_q + 32'd1 == 32'(len_q)) state_d = IDLE;
            RUN:       if (i_finish) state_d = DUMP_PC;
            STEP:      state_d = DUMP_PC;
            DUMP_PC:   if (sect_done) state_d = DUMP_REG;
            DUMP_REG:  if (sect_done) state_d = DUMP_MEM;
`ifdef DEBUG_CYCLE_COUNT_EN
            DUMP_MEM:  if (sect_done) state_d = DUMP_CNT;
            DUMP_CNT:  if (sect_done) state_d = IDLE;
`else
            DUMP_MEM:  if (sect_done) state_d = IDLE;
`endif
            default:   state_d = IDLE;
        endcase
    end

    // Output logic decoded from the current state
    always_comb begin
        o_start    = state_q == RUN;
        o_step     = state_q == STEP;
        o_busy     = state_q != IDLE;
        o_tx_valid = full_q;
        o_tx_data  = sh_q[BYTE_WIDTH-1:0];
    end

    // Datapath: load assembly/strobe, dump capture and shift-out, read address sequencing
    always_comb begin
        len_d      = len_q;
        cnt_d      = cnt_q;
        bcnt_d     = bcnt_q;
        sh_d       = sh_q;
        full_d     = full_q;
        loading_d  = 1'b0;
        instr_d    = instr_q;
        addr_d     = addr_q;
        reg_addr_d = reg_addr_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                bcnt_d     = '0;
                reg_addr_d = '0;
                mem_addr_d = '0;
            end
            LOAD_LEN: if (i_rx_valid) begin
                len_d  = len_new;
                bcnt_d = bcnt_q == 16'd1 ? 16'd0 : 16'd1;
            end
            LOAD_DATA: if (i_rx_valid) begin
                sh_d   = rx_word;
                bcnt_d = load_word ? 16'd0 : bcnt_q + 16'd1;
                if (load_word) begin
                    cnt_d = cnt_q + 32'd1;
                    // words beyond the instruction memory are consumed without a write strobe
                    if (cnt_q < 32'(MAX_INSTR)) begin
                        loading_d = 1'b1;
                        instr_d   = rx_word;
                        addr_d    = DATA_WIDTH'(cnt_q << 2);
                    end
                end
            end
            RUN, STEP: ;
            default: begin
                if (!full_q) begin
                    // capture cycle; advance the read address so the next word is ready a cycle early
                    sh_d   = src;
                    full_d = 1'b1;
                    bcnt_d = '0;
                    if (state_q == DUMP_REG) reg_addr_d = RW'(cnt_q + 32'd1);
                    if (state_q == DUMP_MEM) mem_addr_d = DATA_WIDTH'((cnt_q + 32'd1) << 2);
                end else if (i_tx_ready) begin
                    sh_d   = sh_q >> BYTE_WIDTH;
                    bcnt_d = bcnt_q + 16'd1;
                    if (word_done) begin
                        full_d = 1'b0;
                        cnt_d  = sect_done ? 32'd0 : cnt_q + 32'd1;
                    end
                end
            end
        endcase
`ifdef DEBUG_CYCLE_COUNT_EN
        cyc_d = (o_start || o_step) && cyc_q != '1 ? cyc_q + 32'd1 : cyc_q;
        if (state_q == IDLE && i_rx_valid && (i_rx_data == CMD_R || i_rx_data == CMD_S)) cyc_d = '0;
`endif
    end

    // Datapath registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            len_q      <= '0;
            cnt_q      <= '0;
            bcnt_q     <= '0;
            sh_q       <= '0;
            full_q     <= 1'b0;
            loading_q  <= 1'b0;
            instr_q    <= '0;
            addr_q     <= '0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
`ifdef DEBUG_CYCLE_COUNT_EN
            cyc_q      <= '0;
`endif
        end else begin
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            bcnt_q     <= bcnt_d;
            sh_q       <= sh_d;
            full_q     <= full_d;
            loading_q  <= loading_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            reg_addr_q <= reg_addr_d;
            mem_addr_q <= mem_addr_d;
`ifdef DEBUG_CYCLE_COUNT_EN
            cyc_q      <= cyc_d;
`endif
        end
    end

    assign o_loading     = loading_q;
    assign o_instruccion = instr_q;
    assign o_address     = addr_q;
    assign o_reg_addr    = reg_addr_q;
    assign o_mem_addr    = mem_addr_q;
endmodule

// File: tb/tb_debug_ctrl.sv
// tb_debug_ctrl: directed bench for debug_ctrl (load, garbage/clamp, step, run with backpressure, reset mid-load).
module tb_debug_ctrl;
`ifdef DEBUG_CYCLE_COUNT_EN
    localparam bit WITH_CNT = 1'b1;
`else
    localparam bit WITH_CNT = 1'b0;
`endif
    localparam int DUMP_CYC = 1 + (65 + (WITH_CNT ? 1 : 0)) * 5;

    logic        clk = 0, i_reset = 0, i_rx_valid = 0, i_tx_ready = 1, i_finish = 0;
    logic [7:0]  i_rx_data = 0, o_tx_data;
    logic [31:0] i_pc = 0, i_reg = 0, i_mem = 0, o_mem_addr, o_instruccion, o_address;
    logic [4:0]  o_reg_addr;
    logic        o_tx_valid, o_loading, o_start, o_step, o_busy;
    logic [31:0] regs [32], mem_m [32];
    logic [7:0]  tx_q[$], prev_data;
    logic [31:0] ld_addr[$], ld_data[$];
    logic        prev_stall = 0;
    int          errors = 0, checks = 0, hold_bad = 0, start_cnt = 0, step_cnt = 0, n;

    debug_ctrl dut (
        .i_clock(clk), .i_reset(i_reset), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
        .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready), .i_finish(i_finish),
        .i_pc(i_pc), .i_reg(i_reg), .i_mem(i_mem), .o_reg_addr(o_reg_addr), .o_mem_addr(o_mem_addr),
        .o_instruccion(o_instruccion), .o_address(o_address), .o_loading(o_loading),
        .o_start(o_start), .o_step(o_step), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // synchronous-read register file and data memory with one cycle of latency
    always @(posedge clk) begin
        i_reg <= regs[o_reg_addr];
        i_mem <= mem_m[o_mem_addr[6:2]];
    end

    // monitor away from the active edge: load strobes, TX transfers, stall stability, start/step cycles
    always @(negedge clk) begin
        if (i_reset) begin
            if (o_loading) begin
                ld_addr.push_back(o_address);
                ld_data.push_back(o_instruccion);
            end
            if (o_tx_valid && i_tx_ready) tx_q.push_back(o_tx_data);
            if (prev_stall && (!o_tx_valid || o_tx_data !== prev_data)) hold_bad++;
            start_cnt += int'(o_start);
            step_cnt += int'(o_step);
        end
        prev_stall = o_tx_valid && !i_tx_ready;
        prev_data = o_tx_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_valid = 1;
        i_rx_data = b;
        tick();
        i_rx_valid = 0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send(w[8*b +: 8]);
    endtask

    task automatic check_dump(input string tag, input logic [31:0] pc, input logic [31:0] cyc);
        logic [31:0] w[$];
        int bad = 0, idx = 0;
        w.push_back(pc);
        for (int i = 0; i < 32; i++) w.push_back(32'(i));
        for (int k = 0; k < 32; k++) w.push_back(32'hA0 + 32'(k));
        if (WITH_CNT) w.push_back(cyc);
        chk({tag, "_len"}, 64'(tx_q.size()), 64'(w.size() * 4));
        foreach (w[j]) for (int b = 0; b < 4; b++) begin
            if (idx >= tx_q.size() || tx_q[idx] !== w[j][8*b +: 8]) bad++;
            idx++;
        end
        chk({tag, "_bytes_bad"}, 64'(bad), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            regs[i] = 32'(i);
            mem_m[i] = 32'hA0 + 32'(i);
        end
        repeat (3) tick();
        chk("rst_ctrl", {o_tx_valid, o_tx_data, o_reg_addr, o_loading, o_start, o_step, o_busy}, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_instr", o_instruccion, 0);
        chk("rst_address", o_address, 0);
        i_reset = 1;
        tick();

        // framed load of two words
        send(8'h4C); send(8'h02); send(8'h00);
        send(8'h13); send(8'h00); send(8'h01); send(8'h20);
        chk("ld0_strobe", o_loading, 1);
        chk("ld0_addr", o_address, 32'h0);
        chk("ld0_data", o_instruccion, 32'h2001_0013);
        send(8'hFF);
        chk("ld_strobe_gap", o_loading, 0);
        send(8'hFF); send(8'hFF); send(8'hFF);
        chk("ld1_strobe", o_loading, 1);
        chk("ld1_addr", o_address, 32'h4);
        chk("ld1_data", o_instruccion, 32'hFFFF_FFFF);
        tick();
        chk("ld_strobe_end", o_loading, 0);
        chk("ld_idle", o_busy, 0);

        // garbage bytes, then zero-length load, then clamped load of 257 words
        ld_addr.delete(); ld_data.delete(); tx_q.delete();
        send(8'h00); send(8'h7A); tick();
        chk("garbage_busy", o_busy, 0);
        send(8'h4C); send(8'h00); send(8'h00); tick();
        chk("zero_len_busy", o_busy, 0);
        send(8'h4C); send(8'h01); send(8'h01);
        for (int w = 0; w < 257; w++) send_word(32'hC000_0000 | 32'(w));
        tick(); tick();
        chk("clamp_count", 64'(ld_addr.size()), 256);
        chk("clamp_last_addr", ld_addr.size() == 256 ? ld_addr[255] : 32'hX, 32'h3FC);
        chk("clamp_last_data", ld_data.size() == 256 ? ld_data[255] : 32'hX, 32'hC000_00FF);
        chk("clamp_first_data", ld_data.size() > 0 ? ld_data[0] : 32'hX, 32'hC000_0000);
        chk("clamp_busy", o_busy, 0);
        chk("clamp_no_tx", 64'(tx_q.size()), 0);

        // single step with TX always ready
        i_pc = 32'h8; tx_q.delete(); step_cnt = 0; ld_addr.delete();
        send(8'h53);
        chk("step_strobe", o_step, 1);
        chk("step_tx_early", o_tx_valid, 0);
        tick();
        chk("step_strobe_off", o_step, 0);
        chk("step_tx_bubble", o_tx_valid, 0);
        tick();
        chk("step_first_valid", o_tx_valid, 1);
        chk("step_first_byte", o_tx_data, 8'h08);
        n = 2;
        while (o_busy && n < 2000) begin tick(); n++; end
        chk("step_cycles", 64'(n), 64'(DUMP_CYC));
        chk("step_pulses", 64'(step_cnt), 1);
        check_dump("step", 32'h8, 32'd1);

        // run for five cycles, then dump under toggling backpressure with a stray RX byte
        i_pc = 32'h1234_5678; tx_q.delete(); start_cnt = 0; hold_bad = 0;
        send(8'h52);
        chk("run_start", o_start, 1);
        repeat (4) tick();
        i_finish = 1;
        tick();
        chk("run_start_off", o_start, 0);
        n = 0;
        while (o_busy && n < 3000) begin
            i_tx_ready = ~i_tx_ready;
            i_rx_valid = n == 50;
            i_rx_data = 8'h4C;
            tick();
            n++;
        end
        i_rx_valid = 0; i_finish = 0; i_tx_ready = 1;
        tick();
        chk("run_done", o_busy, 0);
        chk("run_start_cycles", 64'(start_cnt), 5);
        chk("bp_hold", 64'(hold_bad), 0);
        chk("run_no_load", 64'(ld_addr.size()), 0);
        check_dump("run", 32'h1234_5678, 32'd5);

        // reset in the middle of a load word, then a normal step
        send(8'h4C); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        #2 i_reset = 0;
        #1;
        chk("rstmid_ctrl", {o_tx_valid, o_tx_data, o_reg_addr, o_loading, o_start, o_step, o_busy}, 0);
        chk("rstmid_instr", o_instruccion, 0);
        chk("rstmid_address", o_address, 0);
        tick(); tick();
        i_reset = 1;
        tick();
        chk("rstmid_no_load", 64'(ld_addr.size()), 0);
        i_pc = 32'h8; tx_q.delete(); step_cnt = 0;
        send(8'h53);
        chk("rstmid_step", o_step, 1);
        n = 0;
        while (o_busy && n < 2000) begin tick(); n++; end
        chk("rstmid_done", o_busy, 0);
        chk("rstmid_pulses", 64'(step_cnt), 1);
        check_dump("rstmid", 32'h8, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
